// File: rtl/mult_datapath_if.sv
// Command/operand bus of the shift-and-add multiplier datapath.
// The master issues commands and operands; the slave (datapath) returns its state.
interface mult_datapath_if #(
    parameter int N = 4
);
    logic [N-1:0]   a_in;
    logic [N-1:0]   b_in;
    logic           clr;
    logic           ld;
    logic           ldp;
    logic           shb;
    logic           shp;
    logic [2*N-1:0] p_out;
    logic           done;
    logic           err;
    logic [3:0]     step;

    modport master (
        output a_in, b_in, clr, ld, ldp, shb, shp,
        input  p_out, done, err, step
    );

    modport slave (
        input  a_in, b_in, clr, ld, ldp, shb, shp,
        output p_out, done, err, step
    );
endinterface

// File: rtl/mult_datapath.sv
// Command-driven shift-and-add multiplier datapath (MSB-first multiplier scan).
// Registers A, B, P, step, done and err; every output comes straight from a flop.
module mult_datapath #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             reset,
    mult_datapath_if.slave   bus
);

    localparam logic [3:0] N_STEP = 4'(N);

    logic [N-1:0]   a_r;
    logic [N-1:0]   b_r;
    logic [2*N-1:0] p_r;
    logic [3:0]     step_r;
    logic           done_r;
    logic           err_r;

    logic [2:0]     n_cmd;
    logic           multi_cmd;

    // Product accumulate wraps modulo 2^(2N); A is zero-extended.
    function automatic logic [2*N-1:0] acc_add(input logic [2*N-1:0] p,
                                               input logic [N-1:0]   a);
        return p + {{N{1'b0}}, a};
    endfunction

    assign n_cmd     = {2'b00, bus.clr} + {2'b00, bus.ld} + {2'b00, bus.ldp}
                     + {2'b00, bus.shb} + {2'b00, bus.shp};
    assign multi_cmd = (n_cmd > 3'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_r    <= '0;
            b_r    <= '0;
            p_r    <= '0;
            step_r <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (multi_cmd) begin
            err_r <= 1'b1;
        end else if (bus.clr) begin
            p_r    <= '0;
            step_r <= '0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
        end else if (bus.ld) begin
            a_r    <= bus.a_in;
            b_r    <= bus.b_in;
            step_r <= '0;
            done_r <= 1'b0;
        end else if (bus.ldp) begin
            // An extra ldp past the last step is a protocol error, not a wrap.
            if (step_r == N_STEP) begin
                err_r <= 1'b1;
            end else begin
                if (b_r[N-1]) begin
                    p_r <= acc_add(p_r, a_r);
                end
                step_r <= step_r + 4'd1;
                if (step_r + 4'd1 == N_STEP) begin
                    done_r <= 1'b1;
                end
            end
        end else if (bus.shb) begin
            b_r <= {b_r[N-2:0], 1'b0};
        end else if (bus.shp) begin
            p_r <= {p_r[2*N-2:0], 1'b0};
        end
    end

    assign bus.p_out = p_r;
    assign bus.step  = step_r;
    assign bus.done  = done_r;
    assign bus.err   = err_r;

endmodule

// File: tb/tb_mult_datapath.sv
// Directed bench for mult_datapath (N=4) with hand-computed expected values.
module tb_mult_datapath;
    localparam int N = 4;

    logic clk;
    logic reset;
    int   errors;
    int   checks;

    mult_datapath_if #(.N(N)) bus ();

    mult_datapath #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one command for exactly one rising edge, then return to idle.
    task automatic cmd(input logic c, input logic l, input logic lp,
                       input logic sb, input logic sp);
        @(negedge clk);
        bus.clr = c;
        bus.ld  = l;
        bus.ldp = lp;
        bus.shb = sb;
        bus.shp = sp;
        @(posedge clk);
        #1;
        bus.clr = 1'b0;
        bus.ld  = 1'b0;
        bus.ldp = 1'b0;
        bus.shb = 1'b0;
        bus.shp = 1'b0;
    endtask

    task automatic run_mult(input logic [N-1:0] a, input logic [N-1:0] b);
        cmd(1, 0, 0, 0, 0);
        bus.a_in = a;
        bus.b_in = b;
        cmd(0, 1, 0, 0, 0);
        for (int i = 0; i < N - 1; i++) begin
            cmd(0, 0, 1, 0, 0);
            cmd(0, 0, 0, 1, 0);
            cmd(0, 0, 0, 0, 1);
        end
        cmd(0, 0, 1, 0, 0);
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset   = 1'b0;
        bus.a_in = '0;
        bus.b_in = '0;
        bus.clr = 1'b0;
        bus.ld  = 1'b0;
        bus.ldp = 1'b0;
        bus.shb = 1'b0;
        bus.shp = 1'b0;

        #12;
        check("rst_p", 32'(bus.p_out), 32'h0);
        check("rst_step", 32'(bus.step), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_err", 32'(bus.err), 32'd0);
        @(posedge clk);
        #3;
        reset = 1'b1;

        // 13 x 11
        run_mult(4'd13, 4'd11);
        check("13x11_p", 32'(bus.p_out), 32'h8F);
        check("13x11_done", 32'(bus.done), 32'd1);
        check("13x11_step", 32'(bus.step), 32'd4);
        check("13x11_err", 32'(bus.err), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("idle_hold_p", 32'(bus.p_out), 32'h8F);

        // Fifth ldp after done
        cmd(0, 0, 1, 0, 0);
        check("ldp5_p", 32'(bus.p_out), 32'h8F);
        check("ldp5_step", 32'(bus.step), 32'd4);
        check("ldp5_err", 32'(bus.err), 32'd1);
        cmd(1, 0, 0, 0, 0);
        check("clr_err", 32'(bus.err), 32'd0);
        check("clr_p", 32'(bus.p_out), 32'h0);
        check("clr_step", 32'(bus.step), 32'd0);
        check("clr_done", 32'(bus.done), 32'd0);

        // 15 x 15, then shp after done drops the product MSB
        run_mult(4'd15, 4'd15);
        check("15x15_p", 32'(bus.p_out), 32'hE1);
        check("15x15_done", 32'(bus.done), 32'd1);
        cmd(0, 0, 0, 0, 1);
        check("shp_after_done_p", 32'(bus.p_out), 32'hC2);
        check("shp_after_done_done", 32'(bus.done), 32'd1);
        check("shp_after_done_err", 32'(bus.err), 32'd0);

        run_mult(4'd0, 4'd9);
        check("0x9_p", 32'(bus.p_out), 32'h00);
        check("0x9_done", 32'(bus.done), 32'd1);
        run_mult(4'd9, 4'd0);
        check("9x0_p", 32'(bus.p_out), 32'h00);
        check("9x0_done", 32'(bus.done), 32'd1);

        // Two commands at once mid-sequence: B=0110, P=13, step=1 beforehand
        cmd(1, 0, 0, 0, 0);
        bus.a_in = 4'd13;
        bus.b_in = 4'd11;
        cmd(0, 1, 0, 0, 0);
        cmd(0, 0, 1, 0, 0);
        cmd(0, 0, 0, 1, 0);
        cmd(0, 0, 1, 0, 1);
        check("multi_p", 32'(bus.p_out), 32'd13);
        check("multi_step", 32'(bus.step), 32'd1);
        check("multi_err", 32'(bus.err), 32'd1);
        cmd(0, 0, 1, 0, 0);
        check("multi_b_held_p", 32'(bus.p_out), 32'd13);
        check("multi_b_held_step", 32'(bus.step), 32'd2);
        cmd(0, 0, 0, 1, 0);
        cmd(0, 0, 0, 0, 1);
        check("sticky_shp_p", 32'(bus.p_out), 32'd26);
        check("sticky_err_a", 32'(bus.err), 32'd1);
        cmd(0, 1, 0, 0, 0);
        check("sticky_ld_step", 32'(bus.step), 32'd0);
        check("sticky_err_b", 32'(bus.err), 32'd1);

        // Async reset after the sixth command, between clock edges
        cmd(1, 0, 0, 0, 0);
        check("clr_after_err", 32'(bus.err), 32'd0);
        bus.a_in = 4'd13;
        bus.b_in = 4'd11;
        cmd(0, 1, 0, 0, 0);
        cmd(0, 0, 1, 0, 0);
        cmd(0, 0, 0, 1, 0);
        cmd(0, 0, 0, 0, 1);
        cmd(0, 0, 1, 0, 0);
        check("pre_rst_step", 32'(bus.step), 32'd2);
        #1;
        reset = 1'b0;
        #1;
        check("async_rst_p", 32'(bus.p_out), 32'h0);
        check("async_rst_step", 32'(bus.step), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        check("async_rst_err", 32'(bus.err), 32'd0);
        reset = 1'b1;
        run_mult(4'd13, 4'd11);
        check("rerun_13x11_p", 32'(bus.p_out), 32'h8F);
        check("rerun_13x11_done", 32'(bus.done), 32'd1);

        // ld mid-sequence at step=2 (P=26 at that point)
        cmd(1, 0, 0, 0, 0);
        cmd(0, 1, 0, 0, 0);
        cmd(0, 0, 1, 0, 0);
        cmd(0, 0, 0, 1, 0);
        cmd(0, 0, 0, 0, 1);
        cmd(0, 0, 1, 0, 0);
        check("midld_pre_step", 32'(bus.step), 32'd2);
        bus.a_in = 4'd3;
        bus.b_in = 4'd5;
        cmd(0, 1, 0, 0, 0);
        check("midld_step", 32'(bus.step), 32'd0);
        check("midld_done", 32'(bus.done), 32'd0);
        check("midld_p", 32'(bus.p_out), 32'd26);
        run_mult(4'd3, 4'd5);
        check("3x5_p", 32'(bus.p_out), 32'd15);
        check("3x5_done", 32'(bus.done), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
